// File: rtl/lb_fifo_pkg.sv
// -----------------------------------------------------------------------------
// lb_fifo_pkg
// Shared definitions for the local-bus FIFO slave: register offsets, STATUS
// bit positions, CTRL bit positions, the default read value for unmapped
// offsets, a register-decode enum and two small helper functions.
// No ports (package).
// -----------------------------------------------------------------------------
package lb_fifo_pkg;

  // Register offsets on lb_addr[7:0]
  localparam logic [7:0] OFF_DATA   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_CTRL   = 8'h08;
  localparam logic [7:0] OFF_THRESH = 8'h0C;

  // STATUS layout: [15:0] level, then the flag bits below
  localparam int STAT_EMPTY_BIT = 16;
  localparam int STAT_FULL_BIT  = 17;
  localparam int STAT_OVF_BIT   = 18;

  // CTRL layout
  localparam int CTRL_FLUSH_BIT   = 0;
  localparam int CTRL_CLR_OVF_BIT = 1;

  // Value returned for reads of unmapped offsets
  localparam logic [31:0] RD_DEFAULT = 32'hDEADBEEF;

  typedef enum logic [2:0] {
    REG_DATA,
    REG_STATUS,
    REG_CTRL,
    REG_THRESH,
    REG_NONE
  } reg_sel_e;

  function automatic reg_sel_e decode_off(input logic [7:0] off);
    case (off)
      OFF_DATA:   return REG_DATA;
      OFF_STATUS: return REG_STATUS;
      OFF_CTRL:   return REG_CTRL;
      OFF_THRESH: return REG_THRESH;
      default:    return REG_NONE;
    endcase
  endfunction

  function automatic logic [31:0] pack_status(input logic [15:0] level,
                                              input logic        empty,
                                              input logic        full,
                                              input logic        ovf);
    logic [31:0] s;
    s                 = '0;
    s[15:0]           = level;
    s[STAT_EMPTY_BIT] = empty;
    s[STAT_FULL_BIT]  = full;
    s[STAT_OVF_BIT]   = ovf;
    return s;
  endfunction

endpackage

// File: rtl/lb_fifo_ram.sv
// -----------------------------------------------------------------------------
// lb_fifo_ram
// Simple dual-port memory: one synchronous write port, one read port with a
// one-cycle registered read. A read and a write to the same address in the
// same cycle return the old contents. Contents are not reset.
// Ports:
//   clk_i   - clock
//   we_i    - write enable
//   waddr_i - write address
//   wdata_i - write data
//   raddr_i - read address (sampled every cycle)
//   rdata_o - registered read data, valid the cycle after raddr_i
// -----------------------------------------------------------------------------
module lb_fifo_ram #(
  parameter int AW = 4,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [0:(1<<AW)-1];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/lb_fifo_slave.sv
// -----------------------------------------------------------------------------
// lb_fifo_slave
// Local-bus slave fronting a 32-bit first-word-fall-through FIFO. The bus
// pushes words through the DATA register; the fabric pops them from dout.
// Registers (offset on lb_addr[7:0], block selected by lb_addr[31:8]):
//   0x00 DATA   W: push, R: head word (no pop)
//   0x04 STATUS R: [15:0] level, [16] empty, [17] full, [18] overflow (sticky)
//   0x08 CTRL   W: bit0 flush, bit1 clear overflow; reads 0
//   0x0C THRESH R/W [15:0] interrupt level threshold
//   other       reads 32'hDEADBEEF, writes ignored
// Optional feature: define LB_FIFO_IRQ_EN to build the THRESH register and the
// registered irq output; otherwise irq is 0 and THRESH reads 0.
// Ports:
//   clk_lb     - clock for all logic
//   reset_n    - asynchronous active-low reset
//   lb_wr      - one-cycle write strobe
//   lb_rd      - one-cycle read strobe
//   lb_addr    - byte address
//   lb_wr_d    - write data
//   lb_rd_d    - read data, zero unless lb_rd_rdy (OR-combinable)
//   lb_rd_rdy  - read data valid, one cycle after a selected lb_rd
//   dout       - FIFO head word
//   dout_valid - FIFO not empty
//   dout_ready - fabric pop request
//   irq        - level >= THRESH (THRESH != 0) interrupt
// -----------------------------------------------------------------------------
module lb_fifo_slave
  import lb_fifo_pkg::*;
#(
  parameter logic [23:0] BASE_ADDR  = 24'h000001,
  parameter int          DEPTH_LOG2 = 4
) (
  input  logic        clk_lb,
  input  logic        reset_n,
  input  logic        lb_wr,
  input  logic        lb_rd,
  input  logic [31:0] lb_addr,
  input  logic [31:0] lb_wr_d,
  output logic [31:0] lb_rd_d,
  output logic        lb_rd_rdy,
  output logic [31:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        irq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LW    = DEPTH_LOG2 + 1;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic     sel;
  reg_sel_e reg_sel;

  assign sel     = (lb_addr[31:8] == BASE_ADDR);
  assign reg_sel = decode_off(lb_addr[7:0]);

  logic push_req, ctrl_wr, flush, ovf_clr;

  assign push_req = lb_wr && sel && (reg_sel == REG_DATA);
  assign ctrl_wr  = lb_wr && sel && (reg_sel == REG_CTRL);
  assign flush    = ctrl_wr && lb_wr_d[CTRL_FLUSH_BIT];
  assign ovf_clr  = ctrl_wr && lb_wr_d[CTRL_CLR_OVF_BIT];

  // ---------------------------------------------------------------------------
  // FIFO state
  // ---------------------------------------------------------------------------
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  ovf_q, ovf_d;
  logic                  byp_sel_q, byp_sel_d;
  logic [31:0]           byp_data_q, byp_data_d;
  logic [31:0]           ram_rdata;

  logic full, empty, push_ok, ovf_set, pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  // A push while full is dropped even if a pop happens in the same cycle.
  assign push_ok = push_req && !full;
  assign ovf_set = push_req && full;

  // Fabric handshake: dout/dout_valid are held stable until taken; a word is
  // consumed on any rising clk_lb edge where dout_valid=1 and dout_ready=1.
  assign dout_valid = !empty;
  assign pop        = dout_valid && dout_ready;

  // The RAM read port is always addressed with the next head pointer, so its
  // registered output is the head word one cycle later. When the word being
  // written this cycle becomes that head, the RAM would return stale data, so
  // the write data is forwarded through a one-cycle bypass register instead.
  assign dout = byp_sel_q ? byp_data_q : ram_rdata;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    byp_sel_d  = 1'b0;
    byp_data_d = byp_data_q;
    if (flush) begin
      // Flush wins over a same-cycle pop; discard everything stored.
      rd_ptr_d = wr_ptr_q;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
      level_d = level_q + LW'(push_ok) - LW'(pop);
      if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
        byp_sel_d  = 1'b1;
        byp_data_d = lb_wr_d;
      end
    end
  end

  // Set beats clear if both ever land in the same cycle.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (ovf_set) ovf_d = 1'b1;
  end

  always_ff @(posedge clk_lb or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
      byp_sel_q  <= 1'b0;
      byp_data_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      byp_sel_q  <= byp_sel_d;
      byp_data_q <= byp_data_d;
    end
  end

  lb_fifo_ram #(
    .AW (DEPTH_LOG2),
    .DW (32)
  ) u_ram (
    .clk_i   (clk_lb),
    .we_i    (push_ok),
    .waddr_i (wr_ptr_q),
    .wdata_i (lb_wr_d),
    .raddr_i (rd_ptr_d),
    .rdata_o (ram_rdata)
  );

  // ---------------------------------------------------------------------------
  // Threshold register and interrupt
  // ---------------------------------------------------------------------------
  logic [31:0] thresh_rd;

`ifdef LB_FIFO_IRQ_EN
  logic [15:0] thresh_q, thresh_d;
  logic        irq_q, irq_d;

  always_comb begin
    thresh_d = thresh_q;
    if (lb_wr && sel && (reg_sel == REG_THRESH)) thresh_d = lb_wr_d[15:0];
  end

  // Evaluated on next-state values so irq lines up with the new level.
  assign irq_d = (thresh_d != '0) && (16'(level_d) >= thresh_d);

  always_ff @(posedge clk_lb or negedge reset_n) begin
    if (!reset_n) begin
      thresh_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      thresh_q <= thresh_d;
      irq_q    <= irq_d;
    end
  end

  assign thresh_rd = {16'h0000, thresh_q};
  assign irq       = irq_q;
`else
  assign thresh_rd = '0;
  assign irq       = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Read path: registered, zero whenever not ready
  // ---------------------------------------------------------------------------
  logic [31:0] rd_val;
  logic        rd_rdy_q, rd_rdy_d;
  logic [31:0] rd_data_q, rd_data_d;

  always_comb begin
    rd_val = RD_DEFAULT;
    case (reg_sel)
      REG_DATA:   rd_val = dout_valid ? dout : '0;
      REG_STATUS: rd_val = pack_status(16'(level_q), empty, full, ovf_q);
      REG_CTRL:   rd_val = '0;
      REG_THRESH: rd_val = thresh_rd;
      default:    rd_val = RD_DEFAULT;
    endcase
  end

  assign rd_rdy_d  = lb_rd && sel;
  assign rd_data_d = rd_rdy_d ? rd_val : '0;

  always_ff @(posedge clk_lb or negedge reset_n) begin
    if (!reset_n) begin
      rd_rdy_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_rdy_q  <= rd_rdy_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign lb_rd_rdy = rd_rdy_q;
  assign lb_rd_d   = rd_data_q;

endmodule

// File: tb/tb_lb_fifo_slave.sv
module tb_lb_fifo_slave;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk;
  logic        reset_n;
  logic        lb_wr;
  logic        lb_rd;
  logic [31:0] lb_addr;
  logic [31:0] lb_wr_d;
  logic [31:0] lb_rd_d;
  logic        lb_rd_rdy;
  logic [31:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        irq;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  lb_fifo_slave dut (
    .clk_lb     (clk),
    .reset_n    (reset_n),
    .lb_wr      (lb_wr),
    .lb_rd      (lb_rd),
    .lb_addr    (lb_addr),
    .lb_wr_d    (lb_wr_d),
    .lb_rd_d    (lb_rd_d),
    .lb_rd_rdy  (lb_rd_rdy),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .irq        (irq)
  );

  localparam logic [31:0] A_DATA   = 32'h0000_0100;
  localparam logic [31:0] A_STATUS = 32'h0000_0104;
  localparam logic [31:0] A_CTRL   = 32'h0000_0108;
  localparam logic [31:0] A_THRESH = 32'h0000_010C;
  localparam logic [31:0] A_BAD    = 32'h0000_0110;
  localparam logic [31:0] A_BADFC  = 32'h0000_01FC;
  localparam logic [31:0] A_OTHER  = 32'h0000_0200;

`ifdef LB_FIFO_IRQ_EN
  localparam logic [31:0] THR_EXP = 32'h0000_ABCD;
  localparam logic        IRQ_ON  = 1'b1;
`else
  localparam logic [31:0] THR_EXP = 32'h0000_0000;
  localparam logic        IRQ_ON  = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Scoreboard counters and checker
  // ---------------------------------------------------------------------------
  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    lb_wr = 1'b1; lb_addr = a; lb_wr_d = d;
    @(posedge clk); #1;
    lb_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic rdy, output logic [31:0] d);
    @(posedge clk); #1;
    lb_rd = 1'b1; lb_addr = a;
    @(posedge clk); #1;
    lb_rd = 1'b0;
    rdy = lb_rd_rdy;
    d   = lb_rd_d;
  endtask

  task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic        rdy;
    logic [31:0] d;
    bus_read(a, rdy, d);
    check({name, "_rdy"}, {31'b0, rdy}, 32'd1);
    check(name, d, exp);
  endtask

  task automatic pop_check(input string name, input logic [31:0] exp);
    check({name, "_valid"}, {31'b0, dout_valid}, 32'd1);
    check(name, dout, exp);
    dout_ready = 1'b1;
    @(posedge clk); #1;
    dout_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        is_rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_rdy;
    logic [31:0] exp_rd;
    logic        exp_valid;
    logic [31:0] exp_dout;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        rdy;
    logic [31:0] d;
    logic [31:0] w;

    vecs[0]  = '{1'b1, A_STATUS, 32'h0,        1'b1, 32'h0001_0000, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, A_DATA,   32'h1111_1111, 1'b0, 32'h0,        1'b1, 32'h1111_1111};
    vecs[2]  = '{1'b0, A_DATA,   32'h2222_2222, 1'b0, 32'h0,        1'b1, 32'h1111_1111};
    vecs[3]  = '{1'b1, A_STATUS, 32'h0,        1'b1, 32'h0000_0002, 1'b1, 32'h1111_1111};
    vecs[4]  = '{1'b1, A_DATA,   32'h0,        1'b1, 32'h1111_1111, 1'b1, 32'h1111_1111};
    vecs[5]  = '{1'b1, A_CTRL,   32'h0,        1'b1, 32'h0,        1'b1, 32'h1111_1111};
    vecs[6]  = '{1'b1, A_BAD,    32'h0,        1'b1, 32'hDEAD_BEEF, 1'b1, 32'h1111_1111};
    vecs[7]  = '{1'b0, A_BAD,    32'h1234_5678, 1'b0, 32'h0,        1'b1, 32'h1111_1111};
    vecs[8]  = '{1'b1, A_STATUS, 32'h0,        1'b1, 32'h0000_0002, 1'b1, 32'h1111_1111};
    vecs[9]  = '{1'b0, A_THRESH, 32'h0000_ABCD, 1'b0, 32'h0,        1'b1, 32'h1111_1111};
    vecs[10] = '{1'b1, A_THRESH, 32'h0,        1'b1, THR_EXP,       1'b1, 32'h1111_1111};
    vecs[11] = '{1'b0, A_THRESH, 32'h0,        1'b0, 32'h0,        1'b1, 32'h1111_1111};
    vecs[12] = '{1'b0, A_OTHER,  32'h9999_9999, 1'b0, 32'h0,        1'b1, 32'h1111_1111};
    vecs[13] = '{1'b1, A_STATUS, 32'h0,        1'b1, 32'h0000_0002, 1'b1, 32'h1111_1111};
    vecs[14] = '{1'b1, A_OTHER + 32'h4, 32'h0, 1'b0, 32'h0,        1'b1, 32'h1111_1111};
    vecs[15] = '{1'b0, A_CTRL,   32'h0000_0001, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[16] = '{1'b1, A_STATUS, 32'h0,        1'b1, 32'h0001_0000, 1'b0, 32'h0};
    vecs[17] = '{1'b1, A_BADFC,  32'h0,        1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0};

    // Reset
    reset_n = 1'b0; lb_wr = 1'b0; lb_rd = 1'b0; lb_addr = '0; lb_wr_d = '0;
    dout_ready = 1'b0;
    #2;
    check("rst_rdy",   {31'b0, lb_rd_rdy},  32'd0);
    check("rst_rd_d",  lb_rd_d,             32'd0);
    check("rst_valid", {31'b0, dout_valid}, 32'd0);
    check("rst_irq",   {31'b0, irq},        32'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].is_rd) begin
        bus_read(vecs[i].addr, rdy, d);
        check($sformatf("v%0d_rdy", i), {31'b0, rdy}, {31'b0, vecs[i].exp_rdy});
        check($sformatf("v%0d_rd", i), d, vecs[i].exp_rd);
      end else begin
        bus_write(vecs[i].addr, vecs[i].wdata);
      end
      check($sformatf("v%0d_valid", i), {31'b0, dout_valid}, {31'b0, vecs[i].exp_valid});
      if (vecs[i].exp_valid) check($sformatf("v%0d_dout", i), dout, vecs[i].exp_dout);
    end

    // lb_rd_rdy is a single-cycle pulse
    bus_read(A_STATUS, rdy, d);
    check("pulse_hi", {31'b0, rdy}, 32'd1);
    @(posedge clk); #1;
    check("pulse_lo", {31'b0, lb_rd_rdy}, 32'd0);
    check("pulse_d0", lb_rd_d, 32'd0);

    // Overflow: 17 pushes into a 16-deep FIFO
    for (int i = 0; i < 17; i++) bus_write(A_DATA, 32'h100 + i);
    read_check("ovf_status", A_STATUS, 32'h0006_0010);
    check("ovf_head", dout, 32'h100);
    // Push while full with a same-cycle pop: push dropped, pop taken
    @(posedge clk); #1;
    lb_wr = 1'b1; lb_addr = A_DATA; lb_wr_d = 32'h0000_0BAD; dout_ready = 1'b1;
    @(posedge clk); #1;
    lb_wr = 1'b0; dout_ready = 1'b0;
    read_check("fullpop_status", A_STATUS, 32'h0004_000F);
    for (int i = 1; i < 16; i++) pop_check($sformatf("ovf_pop%0d", i), 32'h100 + i);
    check("ovf_drained", {31'b0, dout_valid}, 32'd0);

    // Flush + clear overflow in the same cycle as a pop
    bus_write(A_DATA, 32'h3333_3333);
    bus_write(A_DATA, 32'h4444_4444);
    read_check("pre_flush_status", A_STATUS, 32'h0004_0002);
    @(posedge clk); #1;
    lb_wr = 1'b1; lb_addr = A_CTRL; lb_wr_d = 32'h3; dout_ready = 1'b1;
    @(posedge clk); #1;
    lb_wr = 1'b0; dout_ready = 1'b0;
    check("flush_valid", {31'b0, dout_valid}, 32'd0);
    read_check("flush_status", A_STATUS, 32'h0001_0000);

    // Streaming: push every cycle with dout_ready held high
    @(posedge clk); #1;
    dout_ready = 1'b1;
    w = 32'hA5A5_A5A5;
    lb_wr = 1'b1; lb_addr = A_DATA; lb_wr_d = w; exp_q.push_back(w);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check($sformatf("stream_valid%0d", i), {31'b0, dout_valid}, 32'd1);
      check($sformatf("stream_dout%0d", i), dout, exp_q.pop_front());
      if (i < 7) begin
        w = 32'hA5A5_A5A5 ^ (i + 1);
        lb_wr_d = w; exp_q.push_back(w);
      end else begin
        lb_wr = 1'b0;
      end
    end
    @(posedge clk); #1;
    dout_ready = 1'b0;
    check("stream_empty", {31'b0, dout_valid}, 32'd0);
    check("stream_queue", exp_q.size(), 32'd0);
    read_check("stream_status", A_STATUS, 32'h0001_0000);

    // Interrupt threshold
    bus_write(A_THRESH, 32'd3);
    check("irq_thr_set", {31'b0, irq}, 32'd0);
    for (int k = 1; k <= 3; k++) begin
      bus_write(A_DATA, 32'h7000_0000 + k);
      check($sformatf("irq_push%0d", k), {31'b0, irq}, {31'b0, IRQ_ON && (k == 3)});
    end
    pop_check("irq_pop", 32'h7000_0001);
    check("irq_after_pop", {31'b0, irq}, 32'd0);
    bus_write(A_CTRL, 32'h1);
    bus_write(A_THRESH, 32'd0);

    // Reset in the middle of a read
    bus_write(A_DATA, 32'h5555_5555);
    @(posedge clk); #1;
    lb_rd = 1'b1; lb_addr = A_STATUS;
    @(posedge clk); #1;
    lb_rd = 1'b0;
    reset_n = 1'b0;
    #1;
    check("mid_rst_rdy",   {31'b0, lb_rd_rdy},  32'd0);
    check("mid_rst_rd_d",  lb_rd_d,             32'd0);
    check("mid_rst_valid", {31'b0, dout_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("post_rst_rdy%0d", i), {31'b0, lb_rd_rdy}, 32'd0);
    end
    read_check("post_rst_status", A_STATUS, 32'h0001_0000);
    check("post_rst_irq", {31'b0, irq}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
